// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and
// fixed core parameters.
package hazard_ctrl_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int DEFAULT_FLUSH_DEPTH = 1;
  localparam int FLUSH_CNT_W         = 3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    REDIRECT = 2'd2
  } hz_state_t;

endpackage

// File: rtl/perf_sat_counter.sv
// Saturating event counter with synchronous clear; clear has priority over increment.
module perf_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush generator for the 5-stage core: load-use, EX-resolved redirects
// and data-memory waits, plus lost-cycle performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_DEPTH = DEFAULT_FLUSH_DEPTH,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1_add_i,
  input  logic [REG_ADDR_W-1:0] ID_rs2_add_i,
  input  logic                  ID_use_rs1_i,
  input  logic                  ID_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] EX_rd_add_i,
  input  logic                  EX_RD_en_i,
  input  logic                  EX_branch_i,
  input  logic                  EX_jump_i,
  input  logic                  EX_zero_i,
  input  logic                  MEM_req_i,
  input  logic                  MEM_ready_i,
  input  logic                  cnt_clr_i,
  output logic                  pc_stall_o,
  output logic                  ifid_stall_o,
  output logic                  idex_stall_o,
  output logic                  exmem_stall_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  pc_sel_o,
  output logic [CNT_WIDTH-1:0]  stall_cycles_o,
  output logic [CNT_WIDTH-1:0]  flush_events_o
);

  hz_state_t              state, state_n, cur;
  logic [FLUSH_CNT_W-1:0] fl_cnt, fl_cnt_n;
  logic                   redirect, load_use, mem_wait;

  assign redirect = EX_jump_i | (EX_branch_i & EX_zero_i);
  assign mem_wait = MEM_req_i & ~MEM_ready_i;
  assign load_use = EX_RD_en_i && (EX_rd_add_i != '0) &&
                    ((ID_use_rs1_i && (ID_rs1_add_i == EX_rd_add_i)) ||
                     (ID_use_rs2_i && (ID_rs2_add_i == EX_rd_add_i)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      fl_cnt <= '0;
    end else begin
      state  <= state_n;
      fl_cnt <= fl_cnt_n;
    end
  end

  // While reset is held the strobes behave as in RUN.
  always_comb begin
    cur           = rst ? RUN : state;
    state_n       = cur;
    fl_cnt_n      = fl_cnt;
    pc_stall_o    = 1'b0;
    ifid_stall_o  = 1'b0;
    idex_stall_o  = 1'b0;
    exmem_stall_o = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    pc_sel_o      = 1'b0;
    if (cur == REDIRECT) begin
      // IF/ID keeps being flushed; a flushed register is already a frozen bubble,
      // so its stall stays low to keep flush and stall exclusive.
      ifid_flush_o = 1'b1;
      if (mem_wait) begin
        pc_stall_o    = 1'b1;
        idex_stall_o  = 1'b1;
        exmem_stall_o = 1'b1;
      end else if (fl_cnt <= FLUSH_CNT_W'(1)) begin
        state_n = RUN;
      end else begin
        fl_cnt_n = fl_cnt - FLUSH_CNT_W'(1);
      end
    end else if (mem_wait) begin
      pc_stall_o    = 1'b1;
      ifid_stall_o  = 1'b1;
      idex_stall_o  = 1'b1;
      exmem_stall_o = 1'b1;
      state_n       = MEM_WAIT;
    end else if (redirect) begin
      pc_sel_o     = 1'b1;
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
      state_n      = RUN;
      if (FLUSH_DEPTH > 1) begin
        fl_cnt_n = FLUSH_CNT_W'(FLUSH_DEPTH - 1);
        state_n  = REDIRECT;
      end
    end else begin
      state_n = RUN;
      if (load_use) begin
        pc_stall_o   = 1'b1;
        ifid_stall_o = 1'b1;
        idex_flush_o = 1'b1;
      end
    end
  end

  perf_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_stall_o),
    .clr (cnt_clr_i),
    .cnt (stall_cycles_o)
  );

  perf_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (pc_sel_o),
    .clr (cnt_clr_i),
    .cnt (flush_events_o)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with FLUSH_DEPTH=3 and 4-bit counters.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] ID_rs1_add_i, ID_rs2_add_i, EX_rd_add_i;
  logic       ID_use_rs1_i, ID_use_rs2_i, EX_RD_en_i;
  logic       EX_branch_i, EX_jump_i, EX_zero_i;
  logic       MEM_req_i, MEM_ready_i, cnt_clr_i;
  logic       pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o;
  logic       ifid_flush_o, idex_flush_o, pc_sel_o;
  logic [3:0] stall_cycles_o, flush_events_o;
  logic [6:0] strb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FLUSH_DEPTH(3), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_add_i(ID_rs1_add_i), .ID_rs2_add_i(ID_rs2_add_i),
    .ID_use_rs1_i(ID_use_rs1_i), .ID_use_rs2_i(ID_use_rs2_i),
    .EX_rd_add_i(EX_rd_add_i), .EX_RD_en_i(EX_RD_en_i),
    .EX_branch_i(EX_branch_i), .EX_jump_i(EX_jump_i), .EX_zero_i(EX_zero_i),
    .MEM_req_i(MEM_req_i), .MEM_ready_i(MEM_ready_i), .cnt_clr_i(cnt_clr_i),
    .pc_stall_o(pc_stall_o), .ifid_stall_o(ifid_stall_o),
    .idex_stall_o(idex_stall_o), .exmem_stall_o(exmem_stall_o),
    .ifid_flush_o(ifid_flush_o), .idex_flush_o(idex_flush_o),
    .pc_sel_o(pc_sel_o),
    .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o)
  );

  // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, pc_sel}
  assign strb = {pc_stall_o, ifid_stall_o, idex_stall_o, exmem_stall_o,
                 ifid_flush_o, idex_flush_o, pc_sel_o};

  localparam logic [6:0] S_NONE   = 7'b0000000;
  localparam logic [6:0] S_LDUSE  = 7'b1100010;
  localparam logic [6:0] S_REDIR  = 7'b0000111;
  localparam logic [6:0] S_FLUSH  = 7'b0000100;
  localparam logic [6:0] S_MEMW   = 7'b1111000;
  localparam logic [6:0] S_FREEZE = 7'b1011100;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_strb(input string tag, input logic [6:0] exp);
    #1;
    chk(tag, {9'd0, strb}, {9'd0, exp});
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] st, input logic [3:0] fl);
    chk({tag, "_stall_cnt"}, {12'd0, stall_cycles_o}, {12'd0, st});
    chk({tag, "_flush_cnt"}, {12'd0, flush_events_o}, {12'd0, fl});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_rs1_add_i = 5'd0; ID_rs2_add_i = 5'd0; EX_rd_add_i = 5'd0;
    ID_use_rs1_i = 1'b0; ID_use_rs2_i = 1'b0; EX_RD_en_i = 1'b0;
    EX_branch_i = 1'b0; EX_jump_i = 1'b0; EX_zero_i = 1'b0;
    MEM_req_i = 1'b0; MEM_ready_i = 1'b0; cnt_clr_i = 1'b0;
  endtask

  task automatic load_use_x5();
    EX_RD_en_i = 1'b1; EX_rd_add_i = 5'd5; ID_rs1_add_i = 5'd5; ID_use_rs1_i = 1'b1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    tick();
    chk_cnt("reset", 4'd0, 4'd0);
    load_use_x5();
    chk_strb("reset_run_rules", S_LDUSE);
    tick();
    chk_cnt("reset_no_count", 4'd0, 4'd0);
    rst = 1'b0;
    idle();
    chk_strb("idle", S_NONE);

    // load-use on rs1 and on rs2
    load_use_x5();
    chk_strb("lduse_rs1", S_LDUSE);
    tick();
    idle();
    chk_strb("lduse_one_cycle", S_NONE);
    chk_cnt("lduse_rs1", 4'd1, 4'd0);
    EX_RD_en_i = 1'b1; EX_rd_add_i = 5'd7; ID_rs1_add_i = 5'd3; ID_use_rs1_i = 1'b1;
    ID_rs2_add_i = 5'd7; ID_use_rs2_i = 1'b1;
    chk_strb("lduse_rs2", S_LDUSE);
    tick();
    idle();
    EX_RD_en_i = 1'b1;
    ID_use_rs1_i = 1'b1;
    chk_strb("load_x0", S_NONE);
    tick();
    load_use_x5();
    ID_use_rs1_i = 1'b0;
    chk_strb("no_use_flag", S_NONE);
    tick();
    idle();
    EX_branch_i = 1'b1;
    chk_strb("branch_not_taken", S_NONE);
    tick();
    chk_cnt("after_lduse", 4'd2, 4'd0);

    // taken branch, FLUSH_DEPTH=3; a repeated redirect while flushing is ignored
    EX_zero_i = 1'b1;
    chk_strb("redir_c0", S_REDIR);
    tick();
    chk_strb("redir_c1", S_FLUSH);
    chk_cnt("redir", 4'd2, 4'd1);
    tick();
    idle();
    chk_strb("redir_c2", S_FLUSH);
    tick();
    chk_strb("redir_c3_run", S_NONE);

    // redirect beats simultaneous load-use
    load_use_x5();
    EX_jump_i = 1'b1;
    chk_strb("redir_over_lduse", S_REDIR);
    tick();
    idle();
    chk_strb("redir2_c1", S_FLUSH);
    tick();
    chk_strb("redir2_c2", S_FLUSH);
    tick();
    chk_strb("redir2_run", S_NONE);
    chk_cnt("redir2", 4'd2, 4'd2);

    // memory wait with a pending redirect: 4 frozen cycles, redirect on ready
    MEM_req_i = 1'b1; EX_jump_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_strb("memwait_frozen", S_MEMW);
      tick();
    end
    MEM_ready_i = 1'b1;
    chk_strb("memwait_ready_redir", S_REDIR);
    tick();
    idle();
    chk_strb("memwait_redir_c1", S_FLUSH);
    chk_cnt("memwait", 4'd6, 4'd3);
    tick();
    chk_strb("memwait_redir_c2", S_FLUSH);
    tick();
    chk_strb("memwait_run", S_NONE);

    // memory wait inside REDIRECT freezes the flush countdown
    EX_jump_i = 1'b1;
    chk_strb("redir3_c0", S_REDIR);
    tick();
    idle();
    MEM_req_i = 1'b1;
    chk_strb("redir_freeze_a", S_FREEZE);
    tick();
    chk_strb("redir_freeze_b", S_FREEZE);
    tick();
    MEM_ready_i = 1'b1;
    chk_strb("redir_unfreeze_c1", S_FLUSH);
    tick();
    idle();
    chk_strb("redir_unfreeze_c2", S_FLUSH);
    tick();
    chk_strb("redir_unfreeze_run", S_NONE);
    chk_cnt("freeze", 4'd8, 4'd4);

    // saturation, then clear winning over a simultaneous stall
    load_use_x5();
    for (int i = 0; i < 10; i++) tick();
    chk_cnt("saturate", 4'd15, 4'd4);
    cnt_clr_i = 1'b1;
    tick();
    chk_cnt("clear_wins", 4'd0, 4'd0);
    cnt_clr_i = 1'b0;
    tick();
    chk_cnt("count_after_clear", 4'd1, 4'd0);

    // reset in the middle of REDIRECT and of MEM_WAIT
    idle();
    EX_jump_i = 1'b1;
    tick();
    idle();
    rst = 1'b1;
    chk_strb("rst_in_redirect", S_NONE);
    tick();
    rst = 1'b0;
    chk_strb("after_rst_redirect", S_NONE);
    chk_cnt("rst_mid", 4'd0, 4'd0);
    MEM_req_i = 1'b1;
    tick();
    MEM_req_i = 1'b0;
    rst = 1'b1;
    chk_strb("rst_in_memwait", S_NONE);
    tick();
    rst = 1'b0;
    load_use_x5();
    chk_strb("after_rst_memwait", S_LDUSE);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
